// File: rtl/fft_out_unload.sv
// Read-side unloader for the FFT output buffer: walks one frame of addresses, re-times the
// returned words against the fixed read latency and streams them out through a skid FIFO.
module fft_out_unload #(
    parameter int unsigned LOGPTS = 8,
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned RD_LAT = 3,
    parameter bit          BITREV = 1'b0
) (
    input  logic              clk,
    input  logic              nGrst,
    input  logic              start,
    output logic              busy,
    output logic [LOGPTS-1:0] rA,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              frame_done
);

    localparam int unsigned PTS   = 2 ** LOGPTS;
    localparam int unsigned DEPTH = RD_LAT + 2;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned OW    = $clog2(2 * RD_LAT + 4);
    localparam logic [LOGPTS:0] CNT_LAST = (LOGPTS + 1)'(PTS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_frame_done;
    logic [LOGPTS:0]   r_cnt;
    logic [LOGPTS-1:0] r_ra;
    // Tag pipe: index 0 lines up with rA, index RD_LAT with the matching rd_data.
    logic [RD_LAT:0]   r_pv;
    logic [RD_LAT:0]   r_pf;
    logic [RD_LAT:0]   r_pl;
    logic [DWIDTH+1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_first;
    logic              w_last;
    logic              w_drain_done;
    logic [OW-1:0]     w_occ;
    logic [DWIDTH+1:0] w_head;

    function automatic logic [LOGPTS-1:0] f_order(input logic [LOGPTS-1:0] c);
        logic [LOGPTS-1:0] rev;
        for (int unsigned i = 0; i < LOGPTS; i++) begin
            rev[i] = c[LOGPTS-1-i];
        end
        return BITREV ? rev : c;
    endfunction

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every word already issued will land in the FIFO, so count it against the depth now.
    always_comb begin
        w_occ = OW'(r_count);
        for (int unsigned i = 0; i <= RD_LAT; i++) begin
            w_occ = w_occ + OW'(r_pv[i]);
        end
    end

    assign w_head       = r_mem[r_rptr];
    assign out_valid    = (r_count != '0);
    assign w_pop        = out_valid & out_ready;
    assign w_push       = r_pv[RD_LAT];
    assign w_issue      = (r_state == StRead) && ((w_occ - OW'(w_pop)) < OW'(DEPTH));
    assign w_first      = w_issue && (r_cnt == '0);
    assign w_last       = w_issue && (r_cnt == CNT_LAST);
    assign w_drain_done = (r_state == StDrain) && (r_pv == '0) &&
                          ((r_count == '0) || ((r_count == CW'(1)) && w_pop));

    assign out_data   = w_head[DWIDTH+1:2];
    assign out_first  = out_valid & w_head[1];
    assign out_last   = out_valid & w_head[0];
    assign busy       = r_busy;
    assign rA         = r_ra;
    assign frame_done = r_frame_done;

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_cnt        <= '0;
            r_ra         <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    // A start coincident with frame_done is dropped; the sequencer re-issues it.
                    if (start && !r_frame_done) begin
                        r_state <= StRead;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                StRead: begin
                    if (w_issue) begin
                        r_ra  <= f_order(r_cnt[LOGPTS-1:0]);
                        r_cnt <= r_cnt + (LOGPTS + 1)'(1);
                        if (r_cnt == CNT_LAST) begin
                            r_state <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_drain_done) begin
                        r_state      <= StIdle;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            r_pv <= '0;
            r_pf <= '0;
            r_pl <= '0;
        end else begin
            r_pv <= {r_pv[RD_LAT-1:0], w_issue};
            r_pf <= {r_pf[RD_LAT-1:0], w_first};
            r_pl <= {r_pl[RD_LAT-1:0], w_last};
        end
    end

    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= {rd_data, r_pf[RD_LAT], r_pl[RD_LAT]};
                r_wptr        <= f_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_out_unload.sv
// Scoreboard bench for fft_out_unload: a natural-order 256-point instance and a
// bit-reversed 8-point instance, each fed by a fixed-latency RAM model returning data=addr.
`timescale 1ns/1ps
module tb_fft_out_unload;

    localparam int LOGPTS = 8;
    localparam int DWIDTH = 32;
    localparam int RD_LAT = 3;
    localparam int PTS    = 256;
    localparam int DEPTH  = RD_LAT + 2;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
    } exp_t;

    logic              clk = 1'b0;
    logic              nGrst = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b1;
    logic              busy;
    logic [LOGPTS-1:0] rA;
    logic [DWIDTH-1:0] rd_data;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_first;
    logic              out_last;
    logic              frame_done;

    logic              start_br = 1'b0;
    logic              ready_br = 1'b1;
    logic              busy_br;
    logic [2:0]        rA_br;
    logic [DWIDTH-1:0] rd_data_br;
    logic [DWIDTH-1:0] out_data_br;
    logic              out_valid_br;
    logic              out_first_br;
    logic              out_last_br;
    logic              frame_done_br;

    fft_out_unload #(.LOGPTS(LOGPTS), .DWIDTH(DWIDTH), .RD_LAT(RD_LAT), .BITREV(1'b0)) u_dut (
        .clk        (clk),
        .nGrst      (nGrst),
        .start      (start),
        .busy       (busy),
        .rA         (rA),
        .rd_data    (rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_first  (out_first),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    fft_out_unload #(.LOGPTS(3), .DWIDTH(DWIDTH), .RD_LAT(RD_LAT), .BITREV(1'b1)) u_dut_br (
        .clk        (clk),
        .nGrst      (nGrst),
        .start      (start_br),
        .busy       (busy_br),
        .rA         (rA_br),
        .rd_data    (rd_data_br),
        .out_data   (out_data_br),
        .out_valid  (out_valid_br),
        .out_ready  (ready_br),
        .out_first  (out_first_br),
        .out_last   (out_last_br),
        .frame_done (frame_done_br)
    );

    always #5 clk = ~clk;

    // RAM models: rA presented in cycle n gives data=addr in cycle n+RD_LAT.
    logic [LOGPTS-1:0] ram_pipe [RD_LAT];
    logic [2:0]        ram_pipe_br [RD_LAT];
    always @(posedge clk) begin
        ram_pipe[0]    <= rA;
        ram_pipe_br[0] <= rA_br;
        for (int i = 1; i < RD_LAT; i++) begin
            ram_pipe[i]    <= ram_pipe[i-1];
            ram_pipe_br[i] <= ram_pipe_br[i-1];
        end
    end
    assign rd_data    = {24'h0, ram_pipe[RD_LAT-1]};
    assign rd_data_br = {29'h0, ram_pipe_br[RD_LAT-1]};

    int gcyc = 0;
    always @(posedge clk) gcyc <= gcyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t sb_br[$];
    int   br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int   t0 = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor state, written only by the monitor processes.
    int          n_done = 0;
    int          n_first = 0;
    int          n_last = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    int          max_cnt = 0;
    int          n_done_br = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [1:0]  prev_tags;
    exp_t        mon_e;
    exp_t        mon_br;

    always @(negedge clk) begin
        if (!nGrst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 64'(out_valid), 64'(1));
                check_eq("stall_data", 64'(out_data), 64'(prev_data));
                check_eq("stall_tags", 64'({out_first, out_last}), 64'(prev_tags));
            end
            if (int'(u_dut.r_count) > max_cnt) max_cnt = int'(u_dut.r_count);
            if (out_valid && out_ready) begin
                check_eq("sb_has_word", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check_eq("out_data", 64'(out_data), 64'(mon_e.data));
                    check_eq("out_first", 64'(out_first), 64'(mon_e.first));
                    check_eq("out_last", 64'(out_last), 64'(mon_e.last));
                end
                if (out_first) begin
                    n_first++;
                    first_cyc = gcyc - t0;
                end
                if (out_last) begin
                    n_last++;
                    last_cyc = gcyc - t0;
                end
            end
            if (frame_done) begin
                n_done++;
                check_eq("done_busy_low", 64'(busy), 64'(0));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_tags  = {out_first, out_last};
        end
    end

    always @(negedge clk) begin
        if (nGrst && out_valid_br) begin
            check_eq("br_sb_has_word", 64'(sb_br.size() != 0), 64'(1));
            if (sb_br.size() != 0) begin
                mon_br = sb_br.pop_front();
                check_eq("br_out_data", 64'(out_data_br), 64'(mon_br.data));
                check_eq("br_out_first", 64'(out_first_br), 64'(mon_br.first));
                check_eq("br_out_last", 64'(out_last_br), 64'(mon_br.last));
            end
        end
        if (nGrst && frame_done_br) n_done_br++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for edge 0 and queues the expected frame; returns in cycle 0.
    task automatic pulse_start();
        exp_t e;
        for (int k = 0; k < PTS; k++) begin
            e.data  = 32'(k);
            e.first = (k == 0);
            e.last  = (k == PTS - 1);
            sb.push_back(e);
        end
        start = 1'b1;
        tick();
        t0    = gcyc;
        start = 1'b0;
    endtask

    logic [LOGPTS-1:0] ra25;
    logic [LOGPTS-1:0] ra29;

    // mode 0: ready high; 1: ready low cycles 20-29; 2: random ready; 3: stray start at 50.
    task automatic run_frame(input int mode, output bit seen, output int dcyc, output bit drop);
        int c;
        seen = 1'b0;
        drop = 1'b0;
        dcyc = -1;
        pulse_start();
        for (int i = 0; i < 4000 && !seen; i++) begin
            c = gcyc - t0;
            case (mode)
                1:       out_ready = !(c >= 20 && c <= 29);
                2:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = 1'b1;
            endcase
            start = (mode == 3) && (c == 50);
            @(negedge clk);
            if (c == 25) ra25 = rA;
            if (c == 29) ra29 = rA;
            if (frame_done) begin
                seen = 1'b1;
                dcyc = c;
            end else if (!busy) begin
                drop = 1'b1;
            end
            tick();
        end
        out_ready = 1'b1;
        start     = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   dcyc;
        bit   seen;
        bit   drop;
        bit   saw;
        int   base_done;
        int   base_first;
        int   base_last;
        exp_t e;

        repeat (3) tick();
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_rA", 64'(rA), 64'(0));
        check_eq("rst_valid", 64'(out_valid), 64'(0));
        check_eq("rst_first", 64'(out_first), 64'(0));
        check_eq("rst_last", 64'(out_last), 64'(0));
        check_eq("rst_data", 64'(out_data), 64'(0));
        check_eq("rst_done", 64'(frame_done), 64'(0));
        nGrst = 1'b1;
        repeat (2) tick();

        // Full-rate frame: first word in cycle 5, last in 260, done in 261.
        base_done = n_done;
        run_frame(0, seen, dcyc, drop);
        check_eq("t1_done_seen", 64'(seen), 64'(1));
        check_eq("t1_done_cyc", 64'(dcyc), 64'(261));
        check_eq("t1_first_cyc", 64'(first_cyc), 64'(5));
        check_eq("t1_last_cyc", 64'(last_cyc), 64'(260));
        check_eq("t1_busy_after", 64'(busy), 64'(0));
        check_eq("t1_busy_cont", 64'(drop), 64'(0));
        check_eq("t1_sb_empty", 64'(sb.size()), 64'(0));
        check_eq("t1_done_count", 64'(n_done - base_done), 64'(1));

        // Backpressure for ten cycles shifts the tail by exactly ten cycles.
        tick();
        run_frame(1, seen, dcyc, drop);
        check_eq("t2_done_seen", 64'(seen), 64'(1));
        check_eq("t2_done_cyc", 64'(dcyc), 64'(271));
        check_eq("t2_last_cyc", 64'(last_cyc), 64'(270));
        check_eq("t2_ra_stalled", 64'(ra29), 64'(ra25));
        check_eq("t2_sb_empty", 64'(sb.size()), 64'(0));
        check_eq("t2_fifo_max_ok", 64'(max_cnt <= DEPTH), 64'(1));

        // Three back-to-back frames under random ready.
        base_done  = n_done;
        base_first = n_first;
        base_last  = n_last;
        for (int f = 0; f < 3; f++) begin
            tick();
            run_frame(2, seen, dcyc, drop);
            check_eq("t3_done_seen", 64'(seen), 64'(1));
            check_eq("t3_busy_cont", 64'(drop), 64'(0));
        end
        check_eq("t3_sb_empty", 64'(sb.size()), 64'(0));
        check_eq("t3_done_count", 64'(n_done - base_done), 64'(3));
        check_eq("t3_first_count", 64'(n_first - base_first), 64'(3));
        check_eq("t3_last_count", 64'(n_last - base_last), 64'(3));
        check_eq("t3_fifo_max_ok", 64'(max_cnt <= DEPTH), 64'(1));

        // Bit-reversed 8-point frame.
        tick();
        for (int k = 0; k < 8; k++) begin
            e.data  = 32'(br_tab[k]);
            e.first = (k == 0);
            e.last  = (k == 7);
            sb_br.push_back(e);
        end
        start_br = 1'b1;
        tick();
        start_br = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (frame_done_br) seen = 1'b1;
        end
        check_eq("t4_done_seen", 64'(seen), 64'(1));
        check_eq("t4_sb_empty", 64'(sb_br.size()), 64'(0));
        check_eq("t4_busy_after", 64'(busy_br), 64'(0));

        // Stray start at cycle 50 must not disturb the frame or start another.
        tick();
        base_done = n_done;
        run_frame(3, seen, dcyc, drop);
        check_eq("t5_done_seen", 64'(seen), 64'(1));
        check_eq("t5_done_cyc", 64'(dcyc), 64'(261));
        check_eq("t5_busy_cont", 64'(drop), 64'(0));
        repeat (300) tick();
        check_eq("t5_done_count", 64'(n_done - base_done), 64'(1));
        check_eq("t5_busy_idle", 64'(busy), 64'(0));
        check_eq("t5_valid_idle", 64'(out_valid), 64'(0));
        check_eq("t5_br_done_count", 64'(n_done_br), 64'(1));

        // Asynchronous reset mid-frame abandons it.
        pulse_start();
        while (gcyc - t0 < 100) tick();
        #1 nGrst = 1'b0;
        #1;
        check_eq("t6_busy", 64'(busy), 64'(0));
        check_eq("t6_valid", 64'(out_valid), 64'(0));
        check_eq("t6_first", 64'(out_first), 64'(0));
        check_eq("t6_last", 64'(out_last), 64'(0));
        check_eq("t6_data", 64'(out_data), 64'(0));
        check_eq("t6_done", 64'(frame_done), 64'(0));
        check_eq("t6_rA", 64'(rA), 64'(0));
        sb.delete();
        repeat (3) tick();
        nGrst = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid || busy) saw = 1'b1;
        end
        check_eq("t6_idle_after_reset", 64'(saw), 64'(0));
        tick();
        run_frame(0, seen, dcyc, drop);
        check_eq("t6_done_seen", 64'(seen), 64'(1));
        check_eq("t6_done_cyc", 64'(dcyc), 64'(261));
        check_eq("t6_sb_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
